// File: rtl/axi_llc_burst_sequencer.sv
// Splits one AXI Ax transaction into per-cache-line LLC descriptors by stepping a registered
// channel through the external combinational burst cutter.

// Minimal descriptor type so the block elaborates on its own; real users override desc_t.
typedef struct packed {
  logic x_last;
} axi_llc_seq_desc_default_t;

module axi_llc_burst_sequencer #(
  parameter type         chan_t   = logic,
  parameter type         desc_t   = axi_llc_seq_desc_default_t,
  parameter int unsigned CntWidth = 9
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  chan_t               ax_chan_i,
  input  logic                ax_valid_i,
  output logic                ax_ready_o,
  output chan_t               cut_chan_o,
  input  chan_t               cut_next_i,
  input  desc_t               cut_desc_i,
  output desc_t               desc_o,
  output logic                desc_valid_o,
  input  logic                desc_ready_i,
  output logic                busy_o,
  output logic [CntWidth-1:0] desc_cnt_o
);

  typedef enum logic [0:0] {StIdle, StSplit} state_e;

  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  state_e              state_q, state_d;
  chan_t               chan_q, chan_d;
  logic [CntWidth-1:0] cnt_q, cnt_d, cnt_inc;
  logic                desc_hs, last;

  assign desc_hs = (state_q == StSplit) & desc_ready_i;
  assign last    = cut_desc_i.x_last;
  // Saturate rather than wrap so a too-narrow counter never reads as a small count.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CntOne;

  assign busy_o       = (state_q == StSplit);
  assign desc_valid_o = (state_q == StSplit);
  assign desc_o       = cut_desc_i;
  assign cut_chan_o   = chan_q;
  assign desc_cnt_o   = cnt_q;
  assign ax_ready_o   = (state_q == StIdle) | (desc_hs & last);

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (ax_valid_i) begin
          chan_d  = ax_chan_i;
          cnt_d   = '0;
          state_d = StSplit;
        end
      end
      StSplit: begin
        if (desc_hs) begin
          if (!last) begin
            chan_d = cut_next_i;
            cnt_d  = cnt_inc;
          end else if (ax_valid_i) begin
            // Chain the next transaction without an idle bubble.
            chan_d = ax_chan_i;
            cnt_d  = '0;
          end else begin
            cnt_d   = cnt_inc;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      chan_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      cnt_q   <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  desc_stable_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (desc_valid_o && !desc_ready_i) |=> $stable(desc_o));

  no_ax_hs_mid_split_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(ax_valid_i && ax_ready_o && (state_q == StSplit) && !(desc_hs && last)));
`endif

endmodule

// File: tb/tb_axi_llc_burst_sequencer.sv
// Randomised and directed bench for axi_llc_burst_sequencer with a 32-byte-line cutter stand-in
// and a transaction-level model of the descriptor stream.
module tb_axi_llc_burst_sequencer;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } chan_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic        x_last;
  } desc_t;

  logic       clk = 1'b0;
  logic       rst_ni;
  chan_t      ax_chan, cut_chan, cut_next;
  desc_t      cut_desc, desc_o;
  logic       ax_valid, ax_ready, desc_valid, desc_ready, busy;
  logic [8:0] desc_cnt;

  always #5 clk = ~clk;

  axi_llc_burst_sequencer #(
    .chan_t  (chan_t),
    .desc_t  (desc_t),
    .CntWidth(9)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .ax_chan_i   (ax_chan),
    .ax_valid_i  (ax_valid),
    .ax_ready_o  (ax_ready),
    .cut_chan_o  (cut_chan),
    .cut_next_i  (cut_next),
    .cut_desc_i  (cut_desc),
    .desc_o      (desc_o),
    .desc_valid_o(desc_valid),
    .desc_ready_i(desc_ready),
    .busy_o      (busy),
    .desc_cnt_o  (desc_cnt)
  );

  // Cutter stand-in: one step of line splitting, 32-byte lines.
  int unsigned off, bib, beats;
  always_comb begin
    off      = 32'(cut_chan.addr[4:0]);
    bib      = (32 - off) >> cut_chan.size;
    beats    = 32'(cut_chan.len) + 1;
    cut_next = cut_chan;
    cut_desc = '0;
    cut_desc.addr = cut_chan.addr;
    if (cut_chan.burst == 2'b00 || beats <= bib) begin
      cut_desc.len    = cut_chan.len;
      cut_desc.x_last = 1'b1;
    end else begin
      cut_desc.len    = 8'(bib - 1);
      cut_desc.x_last = 1'b0;
      cut_next.addr   = {cut_chan.addr[31:5] + 27'd1, 5'd0};
      cut_next.len    = 8'(beats - bib - 1);
    end
  end

  int    errors = 0;
  int    checks = 0;
  bit    chk_en = 1'b0;
  desc_t exp_q[$];
  desc_t hs_log[$];
  int    model_cnt = 0;
  bit    m_busy, m_hs, m_last, m_axr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected descriptor list: walk every beat and cut where the line index changes.
  task automatic split(input chan_t c);
    int    bytes, n, start;
    desc_t d;
    if (c.burst == 2'b00) begin
      d = '{addr: c.addr, len: c.len, x_last: 1'b1};
      exp_q.push_back(d);
      return;
    end
    bytes = 1 << c.size;
    n     = int'(c.len) + 1;
    start = 0;
    for (int b = 0; b < n; b++) begin
      if (b == n - 1 ||
          ((int'(c.addr) + b * bytes) >> 5) != ((int'(c.addr) + (b + 1) * bytes) >> 5)) begin
        d.addr   = 32'(int'(c.addr) + start * bytes);
        d.len    = 8'(b - start);
        d.x_last = (b == n - 1);
        exp_q.push_back(d);
        start = b + 1;
      end
    end
  endtask

  // Compare at negedge, then advance the model to what the coming posedge must do.
  always @(negedge clk) begin
    if (chk_en) begin
      m_busy = exp_q.size() != 0;
      m_hs   = m_busy && desc_ready;
      m_last = m_hs && exp_q.size() == 1;
      m_axr  = !m_busy || m_last;
      check("busy", 64'(busy), 64'(m_busy));
      check("desc_valid", 64'(desc_valid), 64'(m_busy));
      check("ax_ready", 64'(ax_ready), 64'(m_axr));
      check("desc_cnt", 64'(desc_cnt), 64'(model_cnt));
      if (m_busy) check("desc_o", 64'(desc_o), 64'(exp_q[0]));
      if (!rst_ni) begin
        exp_q.delete();
        model_cnt = 0;
      end else begin
        if (m_hs) begin
          hs_log.push_back(desc_o);
          void'(exp_q.pop_front());
          if (model_cnt != 511) model_cnt++;
        end
        if (ax_valid && m_axr) begin
          model_cnt = 0;
          split(ax_chan);
        end
      end
    end
  end

  function automatic chan_t mk(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                               input logic [1:0] bt);
    chan_t c;
    c = '{addr: a, len: l, size: s, burst: bt};
    return c;
  endfunction

  task automatic send_ax(input chan_t c);
    bit done;
    done     = 1'b0;
    ax_chan  = c;
    ax_valid = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (ax_ready) done = 1'b1;
    end
    if (!done) check("ax_accept_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    ax_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) check("idle_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
  endtask

  int    base;
  bit    acc;
  chan_t rc;

  initial begin
    rst_ni     = 1'b0;
    ax_valid   = 1'b0;
    ax_chan    = '0;
    desc_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_cut_chan", 64'(cut_chan), 64'(0));
    check("rst_cnt", 64'(desc_cnt), 64'(0));
    check("rst_ax_ready", 64'(ax_ready), 64'(1));
    check("rst_valid", 64'(desc_valid), 64'(0));
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // INCR 0x1000 len 7
    desc_ready = 1'b1;
    base = hs_log.size();
    send_ax(mk(32'h1000, 8'd7, 3'd3, 2'b01));
    wait_idle();
    check("c1_n", 64'(hs_log.size() - base), 64'(2));
    check("c1_d0", 64'(hs_log[base]), 64'({32'h1000, 8'd3, 1'b0}));
    check("c1_d1", 64'(hs_log[base+1]), 64'({32'h1020, 8'd3, 1'b1}));
    check("c1_cnt", 64'(desc_cnt), 64'(2));

    // INCR 0x1010 len 3, first valid one cycle after accept
    base = hs_log.size();
    send_ax(mk(32'h1010, 8'd3, 3'd3, 2'b01));
    check("c2_first_valid", 64'(desc_valid), 64'(1));
    check("c2_d0", 64'(desc_o), 64'({32'h1010, 8'd1, 1'b0}));
    wait_idle();
    check("c2_d1", 64'(hs_log[base+1]), 64'({32'h1020, 8'd1, 1'b1}));

    // FIXED 0x1018 len 15: single descriptor, ax_ready during its handshake
    send_ax(mk(32'h1018, 8'd15, 3'd3, 2'b00));
    check("c3_desc", 64'(desc_o), 64'({32'h1018, 8'd15, 1'b1}));
    check("c3_ax_ready", 64'(ax_ready), 64'(1));
    wait_idle();
    check("c3_cnt", 64'(desc_cnt), 64'(1));

    // Stall desc1 of the first case
    base = hs_log.size();
    send_ax(mk(32'h1000, 8'd7, 3'd3, 2'b01));
    @(posedge clk);
    #1;
    desc_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("c4_stall_desc", 64'(desc_o), 64'({32'h1020, 8'd3, 1'b1}));
      check("c4_stall_ax_ready", 64'(ax_ready), 64'(0));
      @(posedge clk);
    end
    #1;
    desc_ready = 1'b1;
    wait_idle();
    check("c4_n", 64'(hs_log.size() - base), 64'(2));
    check("c4_cnt", 64'(desc_cnt), 64'(2));

    // Back-to-back: second accepted on the first's last handshake
    send_ax(mk(32'h1000, 8'd7, 3'd3, 2'b01));
    send_ax(mk(32'h2000, 8'd0, 3'd3, 2'b01));
    check("c5_busy", 64'(busy), 64'(1));
    check("c5_desc", 64'(desc_o), 64'({32'h2000, 8'd0, 1'b1}));
    check("c5_cnt", 64'(desc_cnt), 64'(0));
    wait_idle();

    // Reset right after desc0 of the first case
    base = hs_log.size();
    send_ax(mk(32'h1000, 8'd7, 3'd3, 2'b01));
    @(posedge clk);
    #1;
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    check("c6_valid", 64'(desc_valid), 64'(0));
    check("c6_busy", 64'(busy), 64'(0));
    check("c6_ax_ready", 64'(ax_ready), 64'(1));
    check("c6_cnt", 64'(desc_cnt), 64'(0));
    repeat (10) @(posedge clk);
    #1;
    check("c6_no_remainder", 64'(hs_log.size() - base), 64'(1));

    // Random traffic; Ax held stable until accepted
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      acc = ax_valid && ax_ready;
      @(posedge clk);
      #1;
      if (!ax_valid || acc) begin
        rc.size  = 3'($urandom_range(0, 3));
        rc.addr  = 32'($urandom_range(0, 4095)) & ~((32'd1 << rc.size) - 32'd1);
        rc.burst = ($urandom_range(0, 4) == 0) ? 2'b00 : 2'b01;
        rc.len   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                               : 8'($urandom_range(0, 15));
        ax_chan  = rc;
        ax_valid = ($urandom_range(0, 2) != 0);
      end
      desc_ready = ($urandom_range(0, 3) != 0);
    end
    ax_valid   = 1'b0;
    desc_ready = 1'b1;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
